// File: rtl/dmem_access_rv_if.sv
// dmem_access_rv_if: request/response and word-bus signals of the load/store unit.
// The slave modport is the unit itself; the master modport is its environment.
interface dmem_access_rv_if;
    logic        iwReq;
    logic        iwWrite;
    logic        iwSignExtend;
    logic [1:0]  iwAccess;
    logic [31:0] iwAddr;
    logic [31:0] iwStoreData;
    logic        owBusy;
    logic        orDone;
    logic [31:0] orLoadData;
    logic [3:0]  orException;
    logic [31:0] orBusAddr;
    logic [31:0] orBusWrData;
    logic [3:0]  orBusByteEn;
    logic        orBusRead;
    logic        orBusWrite;
    logic        iwBusReady;
    logic [31:0] iwBusRdData;
    logic        iwBusErr;

    modport slave (
        input  iwReq, iwWrite, iwSignExtend, iwAccess, iwAddr, iwStoreData,
        output owBusy, orDone, orLoadData, orException,
        output orBusAddr, orBusWrData, orBusByteEn, orBusRead, orBusWrite,
        input  iwBusReady, iwBusRdData, iwBusErr
    );

    modport master (
        output iwReq, iwWrite, iwSignExtend, iwAccess, iwAddr, iwStoreData,
        input  owBusy, orDone, orLoadData, orException,
        input  orBusAddr, orBusWrData, orBusByteEn, orBusRead, orBusWrite,
        output iwBusReady, iwBusRdData, iwBusErr
    );
endinterface

// File: rtl/dmem_access_rv.sv
// dmem_access_rv: RV load/store unit running one aligned word-bus access per request,
// with byte enables, lane replication, load extension, misalignment and bus-timeout faults.
module dmem_access_rv #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic             iwClk,
    input logic             iwRst,
    dmem_access_rv_if.slave bus
);
    localparam logic [1:0] MEM_ACCESS_BYTE            = 2'b00;
    localparam logic [1:0] MEM_ACCESS_HALF_WORD       = 2'b01;
    localparam logic [1:0] MEM_ACCESS_WORD            = 2'b10;
    localparam logic [3:0] EXCEPTION_SUCCESS          = 4'd0;
    localparam logic [3:0] EXCEPTION_ILLEGAL_INSTR    = 4'd1;
    localparam logic [3:0] EXCEPTION_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] EXCEPTION_BUS_FAULT        = 4'd5;
    localparam logic [3:0] EXCEPTION_STORE_MISALIGNED = 4'd6;
    localparam logic [7:0] TIMEOUT_LAST               = 8'(TIMEOUT_CYCLES - 32'd1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic        sext_q, sext_d;
    logic [1:0]  access_q, access_d;
    logic [1:0]  off_q, off_d;
    logic        done_q, done_d;
    logic [31:0] load_data_q, load_data_d;
    logic [3:0]  exception_q, exception_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wr_data_q, bus_wr_data_d;
    logic [3:0]  bus_byte_en_q, bus_byte_en_d;
    logic        bus_read_q, bus_read_d;
    logic        bus_write_q, bus_write_d;

    logic        reserved, misaligned, timeout;
    logic [31:0] rd_shift, load_ext;

    assign reserved   = bus.iwAccess == 2'b11;
    assign misaligned = (bus.iwAccess == MEM_ACCESS_HALF_WORD && bus.iwAddr[0]) ||
                        (bus.iwAccess == MEM_ACCESS_WORD && bus.iwAddr[1:0] != 2'b00);
    assign timeout    = TIMEOUT_CYCLES != 0 && cnt_q == TIMEOUT_LAST;
    assign rd_shift   = bus.iwBusRdData >> {off_q, 3'b000};
    // Word loads ignore the sign-extend flag.
    assign load_ext   = access_q == MEM_ACCESS_BYTE      ? {{24{sext_q & rd_shift[7]}}, rd_shift[7:0]} :
                        access_q == MEM_ACCESS_HALF_WORD ? {{16{sext_q & rd_shift[15]}}, rd_shift[15:0]} :
                                                           bus.iwBusRdData;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        write_d       = write_q;
        sext_d        = sext_q;
        access_d      = access_q;
        off_d         = off_q;
        done_d        = 1'b0;
        load_data_d   = load_data_q;
        exception_d   = exception_q;
        bus_addr_d    = bus_addr_q;
        bus_wr_data_d = bus_wr_data_q;
        bus_byte_en_d = bus_byte_en_q;
        bus_read_d    = bus_read_q;
        bus_write_d   = bus_write_q;
        case (state_q)
            IDLE: if (bus.iwReq) begin
                write_d  = bus.iwWrite;
                sext_d   = bus.iwSignExtend;
                access_d = bus.iwAccess;
                off_d    = bus.iwAddr[1:0];
                if (reserved || misaligned) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    exception_d = reserved    ? EXCEPTION_ILLEGAL_INSTR :
                                  bus.iwWrite ? EXCEPTION_STORE_MISALIGNED : EXCEPTION_LOAD_MISALIGNED;
                end else begin
                    state_d       = REQ;
                    cnt_d         = 8'd0;
                    bus_addr_d    = {bus.iwAddr[31:2], 2'b00};
                    bus_byte_en_d = bus.iwAccess == MEM_ACCESS_BYTE      ? 4'b0001 << bus.iwAddr[1:0] :
                                    bus.iwAccess == MEM_ACCESS_HALF_WORD ? 4'b0011 << bus.iwAddr[1:0] : 4'b1111;
                    bus_wr_data_d = bus.iwAccess == MEM_ACCESS_BYTE      ? {4{bus.iwStoreData[7:0]}} :
                                    bus.iwAccess == MEM_ACCESS_HALF_WORD ? {2{bus.iwStoreData[15:0]}} :
                                                                           bus.iwStoreData;
                    bus_read_d    = !bus.iwWrite;
                    bus_write_d   = bus.iwWrite;
                end
            end
            REQ: if (bus.iwBusReady || timeout) begin
                state_d     = DONE;
                done_d      = 1'b1;
                bus_read_d  = 1'b0;
                bus_write_d = 1'b0;
                exception_d = (!bus.iwBusReady || bus.iwBusErr) ? EXCEPTION_BUS_FAULT : EXCEPTION_SUCCESS;
                load_data_d = (bus.iwBusReady && !bus.iwBusErr && !write_q) ? load_ext : load_data_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iwClk or posedge iwRst) begin
        if (iwRst) begin
            state_q       <= IDLE;
            cnt_q         <= 8'd0;
            write_q       <= 1'b0;
            sext_q        <= 1'b0;
            access_q      <= MEM_ACCESS_BYTE;
            off_q         <= 2'b00;
            done_q        <= 1'b0;
            load_data_q   <= 32'd0;
            exception_q   <= EXCEPTION_SUCCESS;
            bus_addr_q    <= 32'd0;
            bus_wr_data_q <= 32'd0;
            bus_byte_en_q <= 4'd0;
            bus_read_q    <= 1'b0;
            bus_write_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            write_q       <= write_d;
            sext_q        <= sext_d;
            access_q      <= access_d;
            off_q         <= off_d;
            done_q        <= done_d;
            load_data_q   <= load_data_d;
            exception_q   <= exception_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            bus_byte_en_q <= bus_byte_en_d;
            bus_read_q    <= bus_read_d;
            bus_write_q   <= bus_write_d;
        end
    end

    assign bus.owBusy      = state_q != IDLE;
    assign bus.orDone      = done_q;
    assign bus.orLoadData  = load_data_q;
    assign bus.orException = exception_q;
    assign bus.orBusAddr   = bus_addr_q;
    assign bus.orBusWrData = bus_wr_data_q;
    assign bus.orBusByteEn = bus_byte_en_q;
    assign bus.orBusRead   = bus_read_q;
    assign bus.orBusWrite  = bus_write_q;
endmodule

// File: tb/tb_dmem_access_rv.sv
// tb_dmem_access_rv: directed load/store vectors against a scripted word-bus responder.
module tb_dmem_access_rv;
    localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, RSV = 2'b11;
    localparam logic [3:0] OK = 4'd0, ILL = 4'd1, LMIS = 4'd4, BFLT = 4'd5, SMIS = 4'd6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    dmem_access_rv_if bus_if ();
    dmem_access_rv #(.TIMEOUT_CYCLES(4)) dut (.iwClk(clk), .iwRst(rst), .bus(bus_if));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Request in cycle 0; done_at is the cycle (after the request) in which orDone is seen.
    task automatic run(input logic w, input logic s, input logic [1:0] acc, input logic [31:0] a,
                       input logic [31:0] sd, input int waits, input logic respond,
                       input logic [31:0] rd, input logic err,
                       output int done_at, output int rds, output int wrs,
                       output logic [31:0] baddr, output logic [31:0] bwd, output logic [3:0] be);
        done_at = -1; rds = 0; wrs = 0; baddr = 'x; bwd = 'x; be = 'x;
        @(negedge clk);
        bus_if.iwReq = 1'b1; bus_if.iwWrite = w; bus_if.iwSignExtend = s;
        bus_if.iwAccess = acc; bus_if.iwAddr = a; bus_if.iwStoreData = sd;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus_if.iwReq = 1'b0;
            bus_if.iwBusReady = 1'b0;
            bus_if.iwBusErr = 1'b0;
            if (bus_if.orDone) begin
                done_at = k;
                break;
            end
            if (bus_if.orBusRead || bus_if.orBusWrite) begin
                if (rds + wrs == 0) begin
                    baddr = bus_if.orBusAddr; bwd = bus_if.orBusWrData; be = bus_if.orBusByteEn;
                end
                rds += int'(bus_if.orBusRead);
                wrs += int'(bus_if.orBusWrite);
                bus_if.iwBusReady = respond && (rds + wrs == waits + 1);
                bus_if.iwBusRdData = rd;
                bus_if.iwBusErr = err;
            end
        end
        @(negedge clk);
    endtask

    int d, r, wr, seen;
    logic [31:0] ba, wd;
    logic [3:0] be;

    initial begin
        bus_if.iwReq = 0; bus_if.iwWrite = 0; bus_if.iwSignExtend = 0; bus_if.iwAccess = 0;
        bus_if.iwAddr = 0; bus_if.iwStoreData = 0; bus_if.iwBusReady = 0;
        bus_if.iwBusRdData = 0; bus_if.iwBusErr = 0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus_if.owBusy, 0);
        chk("rst_done", bus_if.orDone, 0);
        chk("rst_load", bus_if.orLoadData, 0);
        chk("rst_exc", bus_if.orException, OK);
        chk("rst_strobes", {bus_if.orBusRead, bus_if.orBusWrite}, 0);
        chk("rst_be", bus_if.orBusByteEn, 0);
        chk("rst_addr", bus_if.orBusAddr, 0);
        rst = 1'b0;

        run(0, 0, W, 32'h100, 0, 0, 1, 32'hDEADBEEF, 0, d, r, wr, ba, wd, be);
        chk("lw_done_at", d, 2); chk("lw_rd", r, 1); chk("lw_wr", wr, 0);
        chk("lw_be", be, 4'b1111); chk("lw_addr", ba, 32'h100);
        chk("lw_data", bus_if.orLoadData, 32'hDEADBEEF); chk("lw_exc", bus_if.orException, OK);
        chk("idle_busy", bus_if.owBusy, 0);

        run(0, 1, B, 32'h103, 0, 0, 1, 32'h80FF1234, 0, d, r, wr, ba, wd, be);
        chk("lb_be", be, 4'b1000); chk("lb_addr", ba, 32'h100);
        chk("lb_data", bus_if.orLoadData, 32'hFFFFFF80);
        run(0, 0, B, 32'h103, 0, 0, 1, 32'h80FF1234, 0, d, r, wr, ba, wd, be);
        chk("lbu_data", bus_if.orLoadData, 32'h00000080);

        run(1, 0, H, 32'h102, 32'h0000ABCD, 3, 1, 0, 0, d, r, wr, ba, wd, be);
        chk("sh_wr_cycles", wr, 4); chk("sh_rd", r, 0); chk("sh_wd", wd, 32'hABCDABCD);
        chk("sh_be", be, 4'b1100); chk("sh_done_at", d, 5);
        chk("sh_load_kept", bus_if.orLoadData, 32'h00000080); chk("sh_exc", bus_if.orException, OK);

        run(1, 0, B, 32'h201, 32'h123456A5, 0, 1, 0, 0, d, r, wr, ba, wd, be);
        chk("sb_wd", wd, 32'hA5A5A5A5); chk("sb_be", be, 4'b0010);

        run(0, 0, W, 32'h101, 0, 0, 1, 0, 0, d, r, wr, ba, wd, be);
        chk("lwmis_strobes", r + wr, 0); chk("lwmis_done_at", d, 1);
        chk("lwmis_exc", bus_if.orException, LMIS);
        run(1, 0, W, 32'h102, 0, 0, 1, 0, 0, d, r, wr, ba, wd, be);
        chk("swmis_exc", bus_if.orException, SMIS); chk("swmis_strobes", r + wr, 0);
        run(0, 0, RSV, 32'h100, 0, 0, 1, 0, 0, d, r, wr, ba, wd, be);
        chk("rsv_exc", bus_if.orException, ILL); chk("rsv_done_at", d, 1);

        run(0, 1, H, 32'h202, 0, 1, 1, 32'h81234567, 0, d, r, wr, ba, wd, be);
        chk("lh_data", bus_if.orLoadData, 32'hFFFF8123); chk("lh_be", be, 4'b1100);
        chk("lh_done_at", d, 3);
        run(0, 0, H, 32'h200, 0, 0, 1, 32'h81238765, 0, d, r, wr, ba, wd, be);
        chk("lhu_data", bus_if.orLoadData, 32'h00008765);

        run(0, 0, W, 32'h200, 0, 0, 0, 0, 0, d, r, wr, ba, wd, be);
        chk("to_rd_cycles", r, 4); chk("to_done_at", d, 5);
        chk("to_exc", bus_if.orException, BFLT); chk("to_load_kept", bus_if.orLoadData, 32'h00008765);

        run(0, 0, W, 32'h300, 0, 0, 1, 32'h11111111, 1, d, r, wr, ba, wd, be);
        chk("err_exc", bus_if.orException, BFLT); chk("err_load_kept", bus_if.orLoadData, 32'h00008765);
        chk("err_done_at", d, 2);

        @(negedge clk);
        bus_if.iwReq = 1; bus_if.iwWrite = 0; bus_if.iwAccess = W; bus_if.iwAddr = 32'h400;
        @(negedge clk);
        bus_if.iwReq = 0;
        @(negedge clk);
        chk("mid_read_on", bus_if.orBusRead, 1);
        rst = 1'b1;
        #1;
        chk("mid_read_off", bus_if.orBusRead, 0); chk("mid_busy", bus_if.owBusy, 0);
        chk("mid_be", bus_if.orBusByteEn, 0); chk("mid_addr", bus_if.orBusAddr, 0);
        chk("mid_load", bus_if.orLoadData, 0); chk("mid_exc", bus_if.orException, OK);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen += int'(bus_if.orDone);
        end
        chk("mid_no_done", seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
